// File: rtl/bitlet_pack_sched_if.sv
// Request, packer and tagged-result signals shared by the pack scheduler and
// its surroundings.
interface bitlet_pack_sched_if #(
  parameter int unsigned N_LANE    = 4,
  parameter int unsigned WID_ACC   = 24,
  parameter int unsigned WID_QUANT = 3,
  parameter int unsigned WID_BIN   = 8
);
  localparam int unsigned LW = $clog2(N_LANE);

  logic [N_LANE-1:0]         req_vld;
  logic [N_LANE*WID_ACC-1:0] req_acc;
  logic [N_LANE-1:0]         req_rdy;
  logic                      pk_vld;
  logic [WID_ACC-1:0]        pk_acc;
  logic [WID_QUANT-1:0]      pk_quant;
  logic                      pk_res_vld;
  logic [WID_BIN-1:0]        pk_res;
  logic                      out_vld;
  logic                      out_rdy;
  logic [WID_BIN-1:0]        out_res;
  logic [LW-1:0]             out_lane;

  modport slave (
    input  req_vld, req_acc, pk_res_vld, pk_res, out_rdy,
    output req_rdy, pk_vld, pk_acc, pk_quant, out_vld, out_res, out_lane
  );

  modport master (
    output req_vld, req_acc, pk_res_vld, pk_res, out_rdy,
    input  req_rdy, pk_vld, pk_acc, pk_quant, out_vld, out_res, out_lane
  );
endinterface

// File: rtl/bitlet_pack_sched.sv
// Round-robin scheduler that shares one fixed-point packer among N_LANE
// accumulator requesters, one operation in flight, with a response timeout.
module bitlet_pack_sched #(
  parameter int unsigned N_LANE    = 4,
  parameter int unsigned WID_ACC   = 24,
  parameter int unsigned WID_QUANT = 3,
  parameter int unsigned WID_BIN   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [$clog2(N_LANE)-1:0]   cfg_lane,
  input  logic [WID_QUANT-1:0]        cfg_quant,
  output logic                        busy,
  bitlet_pack_sched_if.slave          bus
);
  localparam int unsigned LW      = $clog2(N_LANE);
  localparam int unsigned WCNT_W  = 2;
  localparam int unsigned TIMEOUT = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        last_grant_q, last_grant_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic                 err, err_d;
  logic                 pk_vld_q, pk_vld_d;
  logic [WID_ACC-1:0]   pk_acc_q, pk_acc_d;
  logic [WID_QUANT-1:0] pk_quant_q, pk_quant_d;
  logic                 out_vld_q, out_vld_d;
  logic [WID_BIN-1:0]   out_res_q, out_res_d;
  logic [LW-1:0]        out_lane_q, out_lane_d;
  logic                 busy_d;
  logic [N_LANE-1:0]    req_rdy_c;

  logic [WID_QUANT-1:0] quant_q [N_LANE];
  logic [WID_ACC-1:0]   acc_lane [N_LANE];

  logic                 win_found;
  logic [LW-1:0]        win_idx;
  logic [LW-1:0]        cand;

  always_comb begin
    for (int i = 0; i < int'(N_LANE); i++) begin
      acc_lane[i] = bus.req_acc[i*WID_ACC +: WID_ACC];
    end
  end

  // Round-robin search starting one past the last accepted lane
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(N_LANE); k++) begin
      cand = LW'(last_grant_q + LW'(k));
      if (!win_found && bus.req_vld[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LW'(N_LANE - 1);
      wcnt_q       <= '0;
      err          <= 1'b0;
      pk_vld_q     <= 1'b0;
      pk_acc_q     <= '0;
      pk_quant_q   <= '0;
      out_vld_q    <= 1'b0;
      out_res_q    <= '0;
      out_lane_q   <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wcnt_q       <= wcnt_d;
      err          <= err_d;
      pk_vld_q     <= pk_vld_d;
      pk_acc_q     <= pk_acc_d;
      pk_quant_q   <= pk_quant_d;
      out_vld_q    <= out_vld_d;
      out_res_q    <= out_res_d;
      out_lane_q   <= out_lane_d;
      busy         <= busy_d;
    end
  end

  // Quant registers; a grant in the same cycle reads the pre-write value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_LANE); i++) begin
        quant_q[i] <= '0;
      end
    end else if (cfg_we) begin
      quant_q[cfg_lane] <= cfg_quant;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wcnt_d       = wcnt_q;
    err_d        = err;
    pk_vld_d     = 1'b0;
    pk_acc_d     = pk_acc_q;
    pk_quant_d   = pk_quant_q;
    out_vld_d    = out_vld_q;
    out_res_d    = out_res_q;
    out_lane_d   = out_lane_q;
    req_rdy_c    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found && !rst) begin
          req_rdy_c[win_idx] = 1'b1;
          pk_vld_d           = 1'b1;
          pk_acc_d           = acc_lane[win_idx];
          pk_quant_d         = quant_q[win_idx];
          out_lane_d         = win_idx;
          last_grant_d       = win_idx;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.pk_res_vld) begin
          out_res_d = bus.pk_res;
          out_vld_d = 1'b1;
          state_d   = S_OUT;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          out_res_d = '0;
          out_vld_d = 1'b1;
          err_d     = 1'b1;
          state_d   = S_OUT;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_OUT: begin
        if (bus.out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.req_rdy  = req_rdy_c;
  assign bus.pk_vld   = pk_vld_q;
  assign bus.pk_acc   = pk_acc_q;
  assign bus.pk_quant = pk_quant_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_res  = out_res_q;
  assign bus.out_lane = out_lane_q;
endmodule

// File: tb/tb_bitlet_pack_sched.sv
// Self-checking bench for bitlet_pack_sched: directed scenarios plus randomized
// operations compared against a transaction-level reference model.
module tb_bitlet_pack_sched;
  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_lane;
  logic [2:0] cfg_quant;
  logic       busy;

  bitlet_pack_sched_if #(.N_LANE(4), .WID_ACC(24), .WID_QUANT(3), .WID_BIN(8)) bus ();

  bitlet_pack_sched #(.N_LANE(4), .WID_ACC(24), .WID_QUANT(3), .WID_BIN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_lane  (cfg_lane),
    .cfg_quant (cfg_quant),
    .busy      (busy),
    .bus       (bus)
  );

  typedef struct {
    logic [3:0]  g;
    int          gcyc;
    logic [23:0] pacc;
    logic [2:0]  pq;
    int          pk_lat;
    bit          pk_one;
    logic [7:0]  ores;
    int          olane;
    int          out_lat;
    bit          hold_ok;
    bit          stable_ok;
    bit          idle_ok;
  } op_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  int         m_last;
  logic [2:0] m_quant [4];
  bit         m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] vld);
    for (int k = 1; k <= 4; k++) begin
      if (vld[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 3;
    m_err  = 1'b0;
    for (int i = 0; i < 4; i++) m_quant[i] = 3'd0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_vld = '0;
    bus.pk_res_vld = 1'b0;
    bus.out_rdy = 1'b0;
    cfg_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int lane, input logic [2:0] q);
    cfg_we = 1'b1;
    cfg_lane = 2'(lane);
    cfg_quant = q;
    tick();
    cfg_we = 1'b0;
    m_quant[lane] = q;
  endtask

  // Drives one full operation from the grant cycle to return-to-IDLE and reports what it saw
  task automatic run_op(input logic [3:0] vld, input logic [95:0] acc, input bit respond,
                        input logic [7:0] res, input int stall, input bit cfg_now,
                        input int cfg_l, input logic [2:0] cfg_q, output op_t o);
    int c;
    bus.req_vld = vld;
    bus.req_acc = acc;
    if (cfg_now) begin
      cfg_we = 1'b1;
      cfg_lane = 2'(cfg_l);
      cfg_quant = cfg_q;
    end
    #1;
    o.g = bus.req_rdy;
    o.gcyc = cyc;
    tick();
    bus.req_vld = '0;
    cfg_we = 1'b0;
    c = 1;
    while (!bus.pk_vld && c < 5) begin tick(); c++; end
    o.pk_lat = c;
    o.pacc = bus.pk_acc;
    o.pq = bus.pk_quant;
    tick(); c++;
    o.pk_one = !bus.pk_vld;
    if (respond) begin
      bus.pk_res_vld = 1'b1;
      bus.pk_res = res;
    end
    tick(); c++;
    bus.pk_res_vld = 1'b0;
    while (!bus.out_vld && c < 12) begin tick(); c++; end
    o.out_lat = c;
    o.ores = bus.out_res;
    o.olane = int'(bus.out_lane);
    o.hold_ok = (bus.pk_acc === o.pacc) && (bus.pk_quant === o.pq);
    o.stable_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      bus.out_rdy = 1'b0;
      bus.req_vld = 4'hF;
      #1;
      if (bus.req_rdy !== 4'h0 || bus.out_vld !== 1'b1 || bus.out_res !== o.ores ||
          int'(bus.out_lane) != o.olane || busy !== 1'b1) o.stable_ok = 1'b0;
      tick();
    end
    bus.req_vld = '0;
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    o.idle_ok = (bus.out_vld === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_vld = 4'hF;
    bus.req_acc = {$urandom, $urandom, $urandom};
    tick();
    tick();
    checks++;
    if ({bus.pk_vld, bus.pk_acc, bus.pk_quant, bus.out_vld, bus.out_res, bus.out_lane, busy, dut.err} !== '0)
      $display("FAIL reset_outputs: got pk_vld=%0b pk_acc=%h pk_quant=%0d out_vld=%0b out_res=%h out_lane=%0d busy=%0b err=%0b want all 0",
               bus.pk_vld, bus.pk_acc, bus.pk_quant, bus.out_vld, bus.out_res, bus.out_lane, busy, dut.err);
    checks++;
    if (bus.req_rdy !== 4'h0) begin
      failures++;
      $display("FAIL reset_req_rdy: got %b want 0000", bus.req_rdy);
    end
    if ({bus.pk_vld, bus.pk_acc, bus.pk_quant, bus.out_vld, bus.out_res, bus.out_lane, busy, dut.err} !== '0)
      failures++;
    bus.req_vld = '0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    op_t o;
    logic [95:0] acc;
    apply_reset();
    cfg_write(2, 3'd3);
    acc = '0;
    acc[48 +: 24] = 24'h000150;
    run_op(4'b0100, acc, 1'b1, 8'h2A, 0, 1'b0, 0, 3'd0, o);
    m_last = 2;
    checks++; if (o.g !== 4'b0100) begin failures++; $display("FAIL basic_grant: got %b want 0100", o.g); end
    checks++; if (o.pk_lat != 1 || !o.pk_one) begin failures++; $display("FAIL basic_pk_vld: got lat=%0d one=%0b want lat=1 one=1", o.pk_lat, o.pk_one); end
    checks++; if (o.pq !== 3'd3 || o.pacc !== 24'h000150) begin failures++; $display("FAIL basic_pk_data: got quant=%0d acc=%h want 3 000150", o.pq, o.pacc); end
    checks++; if (o.out_lat != 3) begin failures++; $display("FAIL basic_out_latency: got %0d want 3", o.out_lat); end
    checks++; if (o.ores !== 8'h2A || o.olane != 2) begin failures++; $display("FAIL basic_out: got res=%h lane=%0d want 2a 2", o.ores, o.olane); end
    checks++; if (!o.idle_ok || !o.hold_ok) begin failures++; $display("FAIL basic_idle: got idle=%0b hold=%0b want 1 1", o.idle_ok, o.hold_ok); end
  endtask

  task automatic test_round_robin();
    op_t o;
    int prev;
    logic [7:0] res;
    apply_reset();
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      res = 8'($urandom);
      run_op(4'hF, {$urandom, $urandom, $urandom}, 1'b1, res, 0, 1'b0, 0, 3'd0, o);
      checks++;
      if (o.g !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_order[%0d]: got %b want lane %0d", i, o.g, i % 4); end
      checks++;
      if (o.ores !== res || o.olane != i % 4) begin failures++; $display("FAIL rr_out[%0d]: got res=%h lane=%0d want %h %0d", i, o.ores, o.olane, res, i % 4); end
      if (i > 0) begin
        checks++;
        if (o.gcyc - prev != 4) begin failures++; $display("FAIL rr_interval[%0d]: got %0d want 4", i, o.gcyc - prev); end
      end
      prev = o.gcyc;
    end
    m_last = 0;
  endtask

  task automatic test_backpressure();
    op_t o;
    logic [3:0] vld;
    int w;
    vld = 4'b1010;
    w = rr_pick(m_last, vld);
    run_op(vld, {$urandom, $urandom, $urandom}, 1'b1, 8'hC3, 10, 1'b0, 0, 3'd0, o);
    m_last = w;
    checks++; if (!o.stable_ok) begin failures++; $display("FAIL stall_stable: got unstable want stable for 10 cycles"); end
    checks++; if (!o.idle_ok) begin failures++; $display("FAIL stall_release: got busy/out_vld high want idle"); end
    checks++; if (o.ores !== 8'hC3 || o.olane != w) begin failures++; $display("FAIL stall_out: got res=%h lane=%0d want c3 %0d", o.ores, o.olane, w); end
  endtask

  task automatic test_cfg_collision();
    op_t o;
    cfg_write(1, 3'd1);
    run_op(4'b0010, {$urandom, $urandom, $urandom}, 1'b1, 8'h11, 0, 1'b1, 1, 3'd5, o);
    m_quant[1] = 3'd5;
    m_last = 1;
    checks++; if (o.pq !== 3'd1) begin failures++; $display("FAIL cfg_collision_old: got %0d want 1", o.pq); end
    run_op(4'b0010, {$urandom, $urandom, $urandom}, 1'b1, 8'h22, 0, 1'b0, 0, 3'd0, o);
    checks++; if (o.pq !== 3'd5) begin failures++; $display("FAIL cfg_collision_new: got %0d want 5", o.pq); end
  endtask

  task automatic test_timeout();
    op_t o;
    logic [3:0] vld;
    int w;
    vld = 4'($urandom_range(1, 15));
    w = rr_pick(m_last, vld);
    run_op(vld, {$urandom, $urandom, $urandom}, 1'b0, 8'hFF, 0, 1'b0, 0, 3'd0, o);
    m_last = w;
    m_err = 1'b1;
    checks++; if (o.out_lat - o.pk_lat != 5) begin failures++; $display("FAIL timeout_latency: got %0d want 5 after pk_vld", o.out_lat - o.pk_lat); end
    checks++; if (o.ores !== 8'h00 || o.olane != w) begin failures++; $display("FAIL timeout_out: got res=%h lane=%0d want 00 %0d", o.ores, o.olane, w); end
    checks++; if (dut.err !== 1'b1) begin failures++; $display("FAIL timeout_err: got %0b want 1", dut.err); end
  endtask

  task automatic test_reset_mid_wait();
    op_t o;
    bit seen;
    bus.req_vld = 4'b0001;
    bus.req_acc = {$urandom, $urandom, $urandom};
    #1;
    tick();
    bus.req_vld = '0;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy: got %0b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    bus.pk_res_vld = 1'b1;
    bus.pk_res = 8'h55;
    tick();
    bus.pk_res_vld = 1'b0;
    checks++;
    if ({bus.pk_vld, bus.pk_acc, bus.pk_quant, bus.out_vld, bus.out_res, bus.out_lane, busy, dut.err} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got out_vld=%0b out_res=%h busy=%0b err=%0b pk_acc=%h want all 0",
               bus.out_vld, bus.out_res, busy, dut.err, bus.pk_acc);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_vld !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin failures++; $display("FAIL midrst_no_out: got activity want none"); end
    run_op(4'b1111, {$urandom, $urandom, $urandom}, 1'b1, 8'h77, 0, 1'b0, 0, 3'd0, o);
    m_last = 0;
    checks++; if (o.g !== 4'b0001 || o.pq !== 3'd0) begin failures++; $display("FAIL midrst_first_grant: got %b quant=%0d want 0001 0", o.g, o.pq); end
  endtask

  task automatic test_random();
    op_t o;
    logic [3:0]  vld;
    logic [95:0] acc;
    bit          respond;
    logic [7:0]  res;
    int          stall;
    bit          cfg_now;
    int          cl;
    logic [2:0]  cq;
    int          w;
    logic [2:0]  exp_q;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(0, 3)), 3'($urandom));
      vld = 4'($urandom_range(1, 15));
      acc = {$urandom, $urandom, $urandom};
      respond = ($urandom_range(0, 7) != 0);
      res = 8'($urandom);
      stall = int'($urandom_range(0, 3));
      cfg_now = ($urandom_range(0, 3) == 0);
      cl = int'($urandom_range(0, 3));
      cq = 3'($urandom);
      w = rr_pick(m_last, vld);
      exp_q = m_quant[w];
      if (cfg_now) m_quant[cl] = cq;
      m_last = w;
      if (!respond) m_err = 1'b1;
      run_op(vld, acc, respond, res, stall, cfg_now, cl, cq, o);
      checks++; if (o.g !== 4'(1 << w)) begin failures++; $display("FAIL rand_grant[%0d]: got %b want lane %0d", n, o.g, w); end
      checks++; if (o.pacc !== acc[w*24 +: 24] || o.pq !== exp_q) begin failures++; $display("FAIL rand_pk[%0d]: got acc=%h q=%0d want %h %0d", n, o.pacc, o.pq, acc[w*24 +: 24], exp_q); end
      checks++; if (o.pk_lat != 1 || !o.pk_one) begin failures++; $display("FAIL rand_pk_vld[%0d]: got lat=%0d one=%0b want 1 1", n, o.pk_lat, o.pk_one); end
      checks++; if (o.out_lat != (respond ? 3 : 6)) begin failures++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, o.out_lat, respond ? 3 : 6); end
      checks++; if (o.ores !== (respond ? res : 8'h00) || o.olane != w) begin failures++; $display("FAIL rand_out[%0d]: got res=%h lane=%0d want %h %0d", n, o.ores, o.olane, respond ? res : 8'h00, w); end
      checks++; if (dut.err !== m_err) begin failures++; $display("FAIL rand_err[%0d]: got %0b want %0b", n, dut.err, m_err); end
      checks++; if (!o.stable_ok || !o.idle_ok || !o.hold_ok) begin failures++; $display("FAIL rand_handshake[%0d]: got stable=%0b idle=%0b hold=%0b want 1 1 1", n, o.stable_ok, o.idle_ok, o.hold_ok); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_lane = '0;
    cfg_quant = '0;
    bus.req_vld = '0;
    bus.req_acc = '0;
    bus.pk_res_vld = 1'b0;
    bus.pk_res = '0;
    bus.out_rdy = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_cfg_collision();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bitlet_pack_sched.md
BITLET_PACK_SCHED -- requirements
Module: bitlet_pack_sched

Interface
REQ-001 Parameter N_LANE, default 4: number of accumulator requesters sharing one fixed-point packer; power of 2, range 2..8.
REQ-002 Parameter WID_ACC, default 24: accumulator width.
REQ-003 Parameter WID_QUANT, default 3: quant select width.
REQ-004 Parameter WID_BIN, default 8: packed result width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cfg_we  in  1  quant config write strobe.
REQ-008 cfg_lane  in  log2(N_LANE)  lane addressed by cfg_we.
REQ-009 cfg_quant  in  WID_QUANT  quant value to store.
REQ-010 req_vld  in  N_LANE  per-lane accumulator valid.
REQ-011 req_acc  in  N_LANE*WID_ACC  per-lane accumulator, lane i at [i*WID_ACC +: WID_ACC].
REQ-012 req_rdy  out  N_LANE  per-lane accept; at most one bit high per cycle.
REQ-013 pk_vld  out  1  issue strobe to packer (its Aacc_vld).
REQ-014 pk_acc  out  WID_ACC  accumulator to packer.
REQ-015 pk_quant  out  WID_QUANT  quant to packer.
REQ-016 pk_res_vld  in  1  packer result valid.
REQ-017 pk_res  in  WID_BIN  packer result.
REQ-018 out_vld  out  1  tagged result valid.
REQ-019 out_rdy  in  1  downstream accept.
REQ-020 out_res  out  WID_BIN  packed result.
REQ-021 out_lane  out  log2(N_LANE)  originating lane.
REQ-022 busy  out  1  high in any state other than IDLE.

Function
REQ-023 FSM states IDLE, ISSUE, WAIT, OUT; one operation in flight at a time.
REQ-024 IDLE: if any req_vld bit is set, assert req_rdy for round-robin winner same cycle, capture its req_acc, its quant register and its index, go ISSUE; otherwise stay.
REQ-025 Round-robin: search starts at lane (last_grant+1) mod N_LANE; last_grant updates only on an accepted request; last_grant resets to N_LANE-1 so lane 0 wins first.
REQ-026 ISSUE: pk_vld=1 for exactly one cycle with captured pk_acc/pk_quant, go WAIT.
REQ-027 pk_acc and pk_quant hold their captured values from ISSUE until the next grant.
REQ-028 WAIT: on pk_res_vld=1 capture pk_res into out_res, go OUT; pk_res_vld outside WAIT is ignored.
REQ-029 WAIT timeout: if pk_res_vld is not seen within 4 cycles of entering WAIT, drive out_res to 0, go OUT, and set sticky flag err (internal, visible via hierarchy, cleared only by rst).
REQ-030 OUT: out_vld=1; out_res and out_lane stable while out_vld=1 and out_rdy=0; on out_rdy=1 go IDLE.
REQ-031 Minimum request-to-out_vld latency: grant cycle t, pk_vld at t+1, pk_res_vld expected t+2, out_vld from t+3; minimum issue interval 4 cycles (respects packer's no-back-to-back res_vld).
REQ-032 No new grant in ISSUE, WAIT or OUT; req_rdy=0 there.
REQ-033 Config: cfg_we writes cfg_quant into quant register cfg_lane at clock edge; a write the same cycle as a grant to that lane: the grant captures the old value.
REQ-034 Config writes never affect an operation already granted.
REQ-035 out_lane equals index captured at grant.

Reset
REQ-036 While rst=1 at a clock edge: state=IDLE, req_rdy=0, pk_vld=0, pk_acc=0, pk_quant=0, out_vld=0, out_res=0, out_lane=0, busy=0, last_grant=N_LANE-1, all quant registers=0, err=0.
REQ-037 rst mid-operation aborts the in-flight item with no out_vld; a pk_res_vld arriving after reset is ignored.
REQ-038 Outputs are registered, except req_rdy, which is combinational from state, req_vld and last_grant.

Verification
REQ-039 Reset, then cfg lane2 quant=3, req_vld=4'b0100 with acc=0x000150 -> req_rdy=4'b0100 at t, pk_vld with pk_quant=3 at t+1, pk model returns 0x2A at t+2, out_vld, out_res=0x2A, out_lane=2 from t+3.
REQ-040 req_vld=4'b1111 held, out_rdy=1 -> grants in order lanes 0,1,2,3,0, each 4 cycles apart.
REQ-041 out_rdy=0 for 10 cycles in OUT -> out_vld, out_res and out_lane constant, req_rdy=0; release -> IDLE next cycle.
REQ-042 cfg_we to lane1 quant=5 same cycle as lane1 grant (old quant=1) -> pk_quant=1; next lane1 grant uses 5.
REQ-043 Packer model never returns pk_res_vld -> out_vld 5 cycles after pk_vld, out_res=0, err=1.
REQ-044 rst asserted in WAIT, pk_res_vld next cycle -> no out_vld, state IDLE, all outputs at reset values.
